shape_hextent_scan: RTL and testbench

Parametrised horizontal-extent finder for the star/shape detection pipeline. After the vertical extent (top row, bottom row, seed column) is known, it walks every row from top to bottom. On each row it scans right and then left from the seed column through a synchronous read-only image memory, and reports the overall leftmost and rightmost lit columns. It replaces separate left/right finders with one engine that has a start/done handshake, correct memory read latency, input checking and early termination.

---
 rtl/shape_hextent_scan.sv | 238 +++++++++++++++++++++++
 tb/tb_shape_hextent_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shape_hextent_scan.sv
// shape_hextent_scan
//
// Horizontal-extent finder for the star/shape detection pipeline. Given the
// vertical extent of a shape (top row, bottom row) and a seed column, it
// walks each row from top to bottom. On each row it scans right and then
// left from the seed column through a synchronous read-only image memory. It
// reports the leftmost and rightmost lit columns seen over all rows.
//
// Ports
//   clk        : clock
//   resetn     : synchronous, active-low reset
//   start      : request; sampled only while idle or done
//   mid_x      : seed column, latched with start
//   top_y      : first row, latched with start
//   bottom_y   : last row (inclusive), latched with start
//   mem_addr   : registered read address, y*IMG_W + x
//   mem_q      : read data, valid the cycle after mem_addr is presented
//   most_left  : leftmost lit column
//   most_right : rightmost lit column
//   busy       : high while a scan is in progress
//   done       : level, high while results are available
//   err        : invalid inputs; meaningful while done=1
module shape_hextent_scan #(
  parameter int IMG_W     = 6,
  parameter int IMG_H     = 6,
  parameter int XW        = 3,
  parameter int YW        = 3,
  parameter int AW        = 6,
  parameter int CW        = 3,
  parameter int THRESHOLD = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] mid_x,
  input  logic [YW-1:0] top_y,
  input  logic [YW-1:0] bottom_y,
  output logic [AW-1:0] mem_addr,
  input  logic [CW-1:0] mem_q,
  output logic [XW-1:0] most_left,
  output logic [XW-1:0] most_right,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // One extra bit on the bound constants so that an image width or height
  // equal to 2^XW / 2^YW does not wrap to zero.
  localparam logic [XW:0]   IMG_W_X = (XW+1)'(IMG_W);
  localparam logic [YW:0]   IMG_H_Y = (YW+1)'(IMG_H);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [AW-1:0] IMG_W_A = AW'(IMG_W);
  localparam logic [CW-1:0] THR     = CW'(THRESHOLD);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    R_ISSUE,
    R_CHECK,
    L_ISSUE,
    L_CHECK,
    DONE
  } stateT;

  stateT         state, stateNext;
  logic [XW-1:0] xReg, xNext;
  logic [YW-1:0] yReg, yNext;
  logic [XW-1:0] midXReg, midXNext;
  logic [YW-1:0] bottomYReg, bottomYNext;
  logic [XW-1:0] mostLeftReg, mostLeftNext;
  logic [XW-1:0] mostRightReg, mostRightNext;
  logic [AW-1:0] memAddrReg, memAddrNext;
  logic          busyReg, busyNext;
  logic          doneReg, doneNext;
  logic          errReg, errNext;

  logic          badInputs;
  logic          lit;
  logic          loadAddr;
  logic          rightEnd;
  logic          leftEnd;
  logic          rowEnd;

  assign badInputs = (top_y > bottom_y) ||
                     ({1'b0, bottom_y} >= IMG_H_Y) ||
                     ({1'b0, mid_x} >= IMG_W_X);
  assign lit = (mem_q > THR);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      xReg         <= '0;
      yReg         <= '0;
      midXReg      <= '0;
      bottomYReg   <= '0;
      mostLeftReg  <= '0;
      mostRightReg <= '0;
      memAddrReg   <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      errReg       <= 1'b0;
    end else begin
      state        <= stateNext;
      xReg         <= xNext;
      yReg         <= yNext;
      midXReg      <= midXNext;
      bottomYReg   <= bottomYNext;
      mostLeftReg  <= mostLeftNext;
      mostRightReg <= mostRightNext;
      memAddrReg   <= memAddrNext;
      busyReg      <= busyNext;
      doneReg      <= doneNext;
      errReg       <= errNext;
    end
  end

  always_comb begin
    stateNext     = state;
    xNext         = xReg;
    yNext         = yReg;
    midXNext      = midXReg;
    bottomYNext   = bottomYReg;
    mostLeftNext  = mostLeftReg;
    mostRightNext = mostRightReg;
    memAddrNext   = memAddrReg;
    errNext       = errReg;
    loadAddr      = 1'b0;
    rightEnd      = 1'b0;
    leftEnd       = 1'b0;
    rowEnd        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          midXNext      = mid_x;
          yNext         = top_y;
          bottomYNext   = bottom_y;
          mostLeftNext  = mid_x;
          mostRightNext = mid_x;
          if (badInputs) begin
            errNext   = 1'b1;
            stateNext = DONE;
          end else begin
            errNext   = 1'b0;
            stateNext = ROW;
          end
        end
      end

      // The seed column is never read; start one step to its right, or go
      // straight to the left side when the seed sits on the right border.
      ROW: begin
        loadAddr = 1'b1;
        if (midXReg < X_LAST) begin
          xNext     = midXReg + 1'b1;
          stateNext = R_ISSUE;
        end else begin
          xNext     = midXReg - 1'b1;
          stateNext = L_ISSUE;
        end
      end

      R_ISSUE: stateNext = R_CHECK;

      R_CHECK: begin
        if (lit) begin
          if (xReg > mostRightReg) mostRightNext = xReg;
          if (xReg == X_LAST) begin
            rightEnd = 1'b1;
          end else begin
            xNext     = xReg + 1'b1;
            loadAddr  = 1'b1;
            stateNext = R_ISSUE;
          end
        end else begin
          rightEnd = 1'b1;
        end
        if (rightEnd) begin
          if (midXReg != '0) begin
            xNext     = midXReg - 1'b1;
            loadAddr  = 1'b1;
            stateNext = L_ISSUE;
          end else begin
            rowEnd = 1'b1;
          end
        end
      end

      L_ISSUE: stateNext = L_CHECK;

      L_CHECK: begin
        if (lit) begin
          if (xReg < mostLeftReg) mostLeftNext = xReg;
          if (xReg == '0) begin
            leftEnd = 1'b1;
          end else begin
            xNext     = xReg - 1'b1;
            loadAddr  = 1'b1;
            stateNext = L_ISSUE;
          end
        end else begin
          leftEnd = 1'b1;
        end
        if (leftEnd) rowEnd = 1'b1;
      end

      default: stateNext = IDLE;
    endcase

    // Row end is decided on the same edge as the final check, so the
    // full-width test must see the extents that check is about to write.
    if (rowEnd) begin
      if ((mostLeftNext == '0) && (mostRightNext == X_LAST)) begin
        stateNext = DONE;
      end else if (yReg == bottomYReg) begin
        stateNext = DONE;
      end else begin
        yNext     = yReg + 1'b1;
        stateNext = ROW;
      end
    end

    // The address is registered on the edge that enters an issue state so
    // the memory sees it during the issue cycle and returns data in the check.
    if (loadAddr) memAddrNext = AW'(yReg) * IMG_W_A + AW'(xNext);

    busyNext = (stateNext != IDLE) && (stateNext != DONE);
    doneNext = (stateNext == DONE);
  end

  assign mem_addr   = memAddrReg;
  assign most_left  = mostLeftReg;
  assign most_right = mostRightReg;
  assign busy       = busyReg;
  assign done       = doneReg;
  assign err        = errReg;

endmodule

// File: tb/tb_shape_hextent_scan.sv
// Testbench for shape_hextent_scan (6x6 image, 3-bit pixels, threshold 0).
module tb_shape_hextent_scan;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [2:0] mid_x;
  logic [2:0] top_y;
  logic [2:0] bottom_y;
  logic [5:0] mem_addr;
  logic [2:0] mem_q;
  logic [2:0] most_left;
  logic [2:0] most_right;
  logic       busy;
  logic       done;
  logic       err;

  logic [2:0]  img [0:63];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] seenAddr = '0;
  logic        busyPrev = 1'b0;
  logic        busySeen = 1'b0;

  typedef struct {
    int          l;
    int          r;
    int          e;
    int          cyc;
    logic [63:0] seen;
  } expT;

  expT sbQ[$];

  always #5 clk = ~clk;

  shape_hextent_scan dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .mid_x      (mid_x),
    .top_y      (top_y),
    .bottom_y   (bottom_y),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .most_left  (most_left),
    .most_right (most_right),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Synchronous read-only image memory
  always @(posedge clk) mem_q <= img[mem_addr];

  // Addresses presented while busy, skipping the first busy cycle, which still
  // shows the previous run's last address.
  always @(negedge clk) begin
    if (busy && busyPrev) seenAddr[mem_addr] = 1'b1;
    if (busy) busySeen = 1'b1;
    busyPrev = busy;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearImg();
    for (int i = 0; i < 64; i++) img[i] = 3'd0;
  endtask

  task automatic lightRow(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) img[y*W + x] = 3'd5;
  endtask

  // Reference walk of the scan: extents, edges until done, addresses read.
  function automatic expT model(input int mx, input int ty, input int by);
    expT m;
    m.l = mx; m.r = mx; m.e = 0; m.cyc = 0; m.seen = '0;
    if (ty > by || by >= W || mx >= W) begin
      m.e = 1;
      return m;
    end
    for (int y = ty; y <= by; y++) begin
      m.cyc += 1;
      if (mx < W - 1) begin
        for (int x = mx + 1; x < W; x++) begin
          m.cyc += 2;
          m.seen[y*W + x] = 1'b1;
          if (img[y*W + x] == 3'd0) break;
          if (x > m.r) m.r = x;
        end
      end
      if (mx > 0) begin
        for (int x = mx - 1; x >= 0; x--) begin
          m.cyc += 2;
          m.seen[y*W + x] = 1'b1;
          if (img[y*W + x] == 3'd0) break;
          if (x < m.l) m.l = x;
        end
      end
      if (m.l == 0 && m.r == W - 1) break;
    end
    return m;
  endfunction

  task automatic runScan(input string tag, input int mx, input int ty, input int by,
                         input bit glitch, input int expL, input int expR, input int expCyc);
    expT e;
    int  k;
    sbQ.push_back(model(mx, ty, by));
    seenAddr = '0;
    busySeen = 1'b0;
    @(negedge clk);
    start = 1'b1; mid_x = 3'(mx); top_y = 3'(ty); bottom_y = 3'(by);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 300) begin
      // A start pulse with different inputs while busy must be ignored.
      if (glitch && k == 3) begin
        start = 1'b1; mid_x = 3'd0; top_y = 3'd0; bottom_y = 3'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    e = sbQ.pop_front();
    check({tag, ".done"},     64'(done),       64'(1));
    check({tag, ".left"},     64'(most_left),  64'(e.l));
    check({tag, ".right"},    64'(most_right), 64'(e.r));
    check({tag, ".err"},      64'(err),        64'(e.e));
    check({tag, ".cycles"},   64'(k),          64'(e.cyc));
    check({tag, ".addrs"},    seenAddr,        e.seen);
    check({tag, ".busy"},     64'(busy),       64'(0));
    check({tag, ".busySeen"}, 64'(busySeen),   64'(e.e == 0));
    check({tag, ".leftK"},    64'(most_left),  64'(expL));
    check({tag, ".rightK"},   64'(most_right), 64'(expR));
    check({tag, ".cyclesK"},  64'(k),          64'(expCyc));
    $display("scan %s: mid=%0d top=%0d bot=%0d left=%0d right=%0d err=%0b edges=%0d",
             tag, mx, ty, by, most_left, most_right, err, k);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".left"},  64'(most_left),  64'(0));
    check({tag, ".right"}, 64'(most_right), 64'(0));
    check({tag, ".addr"},  64'(mem_addr),   64'(0));
    check({tag, ".busy"},  64'(busy),       64'(0));
    check({tag, ".done"},  64'(done),       64'(0));
    check({tag, ".err"},   64'(err),        64'(0));
    $display("reset %s: left=%0d right=%0d addr=%0d busy=%0b done=%0b err=%0b",
             tag, most_left, most_right, mem_addr, busy, done, err);
  endtask

  task automatic diamond();
    clearImg();
    lightRow(1, 2, 2);
    lightRow(2, 0, 4);
    lightRow(3, 1, 3);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mid_x = '0; top_y = '0; bottom_y = '0;
    clearImg();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("por");
    @(negedge clk) resetn = 1'b1;

    // Single row, lit at x=1..3
    clearImg(); lightRow(2, 1, 3);
    runScan("single", 2, 2, 2, 1'b0, 1, 3, 9);

    // Diamond over rows 1..3; no early termination since right edge is 4
    diamond();
    runScan("diamond", 2, 1, 3, 1'b0, 0, 4, 25);

    // Full-width row 1 terminates early; rows 2..4 never addressed
    clearImg(); lightRow(1, 0, 5); lightRow(2, 0, 5); lightRow(3, 0, 5); lightRow(4, 0, 5);
    runScan("early", 3, 1, 4, 1'b0, 0, 5, 11);
    check("early.rows2to4", seenAddr & {28'd0, 24'hFFFFFF, 12'd0}, 64'd0);

    // Seed on right border: one read at 3*6+4
    clearImg(); lightRow(3, 0, 3);
    runScan("seedRight", 5, 3, 3, 1'b0, 5, 5, 3);
    check("seedRight.addr22", seenAddr, 64'd1 << 22);

    // Seed on left border: left phase skipped
    clearImg(); lightRow(0, 0, 2);
    runScan("seedLeft", 0, 0, 0, 1'b0, 0, 2, 7);

    // Invalid inputs
    runScan("topGtBot", 1, 4, 2, 1'b0, 1, 1, 0);
    runScan("midOut", 6, 0, 1, 1'b0, 6, 6, 0);
    runScan("botOut", 2, 0, 6, 1'b0, 2, 2, 0);

    // Start pulses while busy are ignored
    diamond();
    runScan("glitch", 2, 1, 3, 1'b1, 0, 4, 25);

    // Reset mid-scan, with a pending start and a start coincident with reset
    @(negedge clk);
    start = 1'b1; mid_x = 3'd2; top_y = 3'd1; bottom_y = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checkAllZero("midScan");
    @(negedge clk);
    resetn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checkAllZero("afterRst");

    runScan("rerun", 2, 1, 3, 1'b0, 0, 4, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
